// File: rtl/fetch_pkg.sv
// Shared types for the prefetch front-end.
//   fetch_word_t : one bus response word plus its error tag
//   OPC_32B      : low two opcode bits marking an uncompressed instruction
//   is_rvc()     : true when the given opcode bits denote a 16-bit instruction
package fetch_pkg;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } fetch_word_t;

    localparam logic [1:0] OPC_32B = 2'b11;

    function automatic logic is_rvc(input logic [1:0] opc);
        return opc != OPC_32B;
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// In-order response buffer for fetched words.
//   clk, rstn      : clock, async active-low reset
//   push, wdata    : append one word (caller guarantees a free slot)
//   pop            : drop the front word (caller guarantees non-empty)
//   clear          : empty the buffer; dominates push and pop
//   count          : current occupancy
//   w0/w0_vld      : front word and its presence
//   w1/w1_vld      : word behind the front and its presence
module prefetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 3,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  fetch_word_t   wdata,
    input  logic          pop,
    input  logic          clear,
    output logic [CW-1:0] count,
    output fetch_word_t   w0,
    output logic          w0_vld,
    output fetch_word_t   w1,
    output logic          w1_vld
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_word_t   mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w0     = mem[rd_ptr];
    assign w1     = mem[ptr_inc(rd_ptr)];
    assign w0_vld = (count != '0);
    assign w1_vld = (count > CW'(1));

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/prefetch_aligner.sv
// Instruction fetch front-end: pipelined bus master, response buffer and
// 16/32-bit instruction aligner.
//   clk, rstn                 : clock, async active-low reset
//   req_o/gnt_i/addr_o        : bus request channel (issue on req_o && gnt_i)
//   rvalid_i/rdata_i/err_i    : in-order bus responses, one per grant
//   redirect_i/redirect_pc_i  : one-cycle PC change, flushes all fetch state
//   valid_o/ready_i           : instruction handshake toward decode
//   instr_o/pc_o              : instruction and its address
//   compressed_o              : instr_o is 16-bit ([31:16] zero)
//   err_o                     : a word feeding instr_o carried a bus error
module prefetch_aligner
    import fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0,
    parameter int          NUM_REQS = 2,
    parameter int          DEPTH    = NUM_REQS + 1
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        req_o,
    input  logic        gnt_i,
    output logic [31:0] addr_o,
    input  logic        rvalid_i,
    input  logic [31:0] rdata_i,
    input  logic        err_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        compressed_o,
    output logic        err_o
);

    localparam int CW  = $clog2(NUM_REQS + 1);
    localparam int FCW = $clog2(DEPTH + 1);

    logic          run;          // keeps req_o low through the reset cycle
    logic [29:0]   fetch_wa;     // word address of the next fetch
    logic [CW-1:0] outstanding, out_nxt, discard;
    logic          fault_hold;
    logic          req_hold;     // request presented but not yet granted

    logic          grant, rsp_keep, push, pop_fire, pop_word, err_int;
    logic [FCW-1:0] occ;
    fetch_word_t   w0, w1;
    logic          w0_vld, w1_vld;
    logic          unused_w1;

    assign grant    = req_o && gnt_i;
    assign addr_o   = {fetch_wa, 2'b00};
    assign rsp_keep = rvalid_i && (discard == '0);
    assign push     = rsp_keep && !redirect_i;
    assign pop_fire = valid_o && ready_i && !redirect_i;

    // Every grant reserves a buffer slot up front, so the buffer cannot
    // overflow. A pending request stays up until granted: the reserved sum
    // never grows while waiting, so the slot is still guaranteed.
    assign req_o = run && (req_hold ||
                   (!fault_hold && int'(outstanding) < NUM_REQS &&
                    int'(occ) + int'(outstanding) < DEPTH));

    always_comb begin
        out_nxt = outstanding;
        if (grant && !rvalid_i)      out_nxt = outstanding + CW'(1);
        else if (!grant && rvalid_i) out_nxt = outstanding - CW'(1);
    end

    prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rstn   (rstn),
        .push   (push),
        .wdata  ('{data: rdata_i, err: err_i}),
        .pop    (pop_fire && pop_word),
        .clear  (redirect_i),
        .count  (occ),
        .w0     (w0),
        .w0_vld (w0_vld),
        .w1     (w1),
        .w1_vld (w1_vld)
    );

    // Only the low half of the second word can ever reach the output.
    assign unused_w1 = ^w1.data[31:16];

    always_comb begin
        valid_o      = 1'b0;
        instr_o      = w0.data;
        compressed_o = 1'b0;
        err_int      = w0.err;
        pop_word     = 1'b0;
        if (!pc_o[1]) begin
            compressed_o = is_rvc(w0.data[1:0]);
            instr_o      = compressed_o ? {16'h0, w0.data[15:0]} : w0.data;
            valid_o      = w0_vld;
            pop_word     = !compressed_o;
        end else begin
            compressed_o = is_rvc(w0.data[17:16]);
            pop_word     = 1'b1;
            if (compressed_o) begin
                instr_o = {16'h0, w0.data[31:16]};
                valid_o = w0_vld;
            end else begin
                instr_o = {w1.data[15:0], w0.data[31:16]};
                // A faulting first half is delivered alone: fetch has
                // stopped, so its second half may never arrive.
                valid_o = w0_vld && (w1_vld || w0.err);
                err_int = w0.err || (w1_vld && w1.err);
            end
        end
        err_o = valid_o && err_int;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run         <= 1'b0;
            fetch_wa    <= PC_RESET[31:2];
            pc_o        <= PC_RESET;
            outstanding <= '0;
            discard     <= '0;
            fault_hold  <= 1'b0;
            req_hold    <= 1'b0;
        end else begin
            run         <= 1'b1;
            outstanding <= out_nxt;
            if (redirect_i) begin
                // Everything still in flight after this edge is stale,
                // including a same-cycle grant; a same-cycle response is
                // dropped and already accounted for in out_nxt.
                discard    <= out_nxt;
                pc_o       <= redirect_pc_i;
                fetch_wa   <= redirect_pc_i[31:2];
                fault_hold <= 1'b0;
                req_hold   <= 1'b0;
            end else begin
                if (rvalid_i && discard != '0) discard <= discard - CW'(1);
                if (grant)                     fetch_wa <= fetch_wa + 30'd1;
                if (pop_fire)                  pc_o <= pc_o + (compressed_o ? 32'd2 : 32'd4);
                if (push && err_i)             fault_hold <= 1'b1;
                req_hold <= req_o && !gnt_i;
            end
        end
    end

endmodule

// File: tb/tb_prefetch_aligner.sv
module tb_prefetch_aligner;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_o, gnt_i;
    logic [31:0] addr_o;
    logic        rvalid_i, err_i;
    logic [31:0] rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        valid_o, ready_i;
    logic [31:0] instr_o, pc_o;
    logic        compressed_o, err_o;

    prefetch_aligner #(.PC_RESET(32'h0), .NUM_REQS(2), .DEPTH(3)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .req_o         (req_o),
        .gnt_i         (gnt_i),
        .addr_o        (addr_o),
        .rvalid_i      (rvalid_i),
        .rdata_i       (rdata_i),
        .err_i         (err_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .compressed_o  (compressed_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] instr; logic [31:0] pc; logic comp; logic err; int cyc; } rec_t;
    typedef struct { logic [31:0] addr; int due; } bus_t;

    rec_t        got[$];
    bus_t        bq[$];
    logic [31:0] mem [0:511];
    int          lat = 1;
    logic        gnt_en = 1'b1;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    int          cyc = 0, n_gnt = 0, max_q = 0;
    int          total = 0, bad = 0;
    int          gb = 0, nb = 0;

    // Bus slave + consumer monitor, both acting half a cycle before the edge.
    always @(negedge clk) begin : bus
        bus_t b;
        cyc++;
        if (!rstn) begin
            bq.delete();
            rvalid_i = 1'b0; rdata_i = '0; err_i = 1'b0; gnt_i = 1'b0;
        end else begin
            rvalid_i = 1'b0; rdata_i = '0; err_i = 1'b0;
            if (bq.size() > 0 && bq[0].due <= cyc) begin
                b = bq.pop_front();
                rvalid_i = 1'b1;
                rdata_i  = mem[b.addr[10:2]];
                err_i    = (b.addr == err_addr);
            end
            gnt_i = gnt_en;
            if (req_o && gnt_i) begin
                bq.push_back('{addr_o, cyc + lat});
                n_gnt++;
            end
            if (bq.size() > max_q) max_q = bq.size();
            if (valid_o && ready_i) got.push_back('{instr_o, pc_o, compressed_o, err_o, cyc});
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        @(posedge clk); #1;
        redirect_pc_i = pc; redirect_i = 1'b1;
        @(posedge clk); #1;
        redirect_i = 1'b0;
        gb = got.size(); nb = n_gnt;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        wait_cyc(3);
        total++; if (req_o !== 1'b0)   begin bad++; $display("FAIL reset_req got=%b exp=0", req_o); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        total++; if (err_o !== 1'b0)   begin bad++; $display("FAIL reset_err got=%b exp=0", err_o); end
        total++; if (pc_o !== 32'h0)   begin bad++; $display("FAIL reset_pc got=%h exp=0", pc_o); end
        rstn = 1'b1;
    endtask

    task automatic test_stream;
        logic [31:0] ep[3], ei[3];
        ep = '{32'h0, 32'h4, 32'h8};
        ei = '{32'h0000_0013, 32'h0000_1013, 32'h0000_2013};
        gb = got.size();
        wait_cyc(20);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (got.size() <= gb + i) begin bad++; $display("FAIL stream[%0d] missing exp pc=%h", i, ep[i]); end
            else if (got[gb+i].pc !== ep[i] || got[gb+i].instr !== ei[i] || got[gb+i].comp !== 1'b0 || got[gb+i].err !== 1'b0) begin
                bad++; $display("FAIL stream[%0d] pc=%h instr=%h c=%b exp pc=%h instr=%h c=0", i, got[gb+i].pc, got[gb+i].instr, got[gb+i].comp, ep[i], ei[i]);
            end
        end
        total++;
        if (got.size() < gb + 10) begin bad++; $display("FAIL stream_rate count=%0d exp>=10", got.size() - gb); end
        else if (got[gb+9].cyc - got[gb+4].cyc != 5) begin bad++; $display("FAIL stream_rate cycles=%0d exp=5", got[gb+9].cyc - got[gb+4].cyc); end
        total++; if (max_q > 2) begin bad++; $display("FAIL stream_outstanding got=%0d exp<=2", max_q); end
    endtask

    task automatic test_rvc;
        logic [31:0] ep[3], ei[3];
        logic        ec[3];
        ep = '{32'h200, 32'h202, 32'h204};
        ei = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0013};
        ec = '{1'b1, 1'b1, 1'b0};
        do_redirect(32'h200);
        wait_cyc(10);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (got.size() <= gb + i) begin bad++; $display("FAIL rvc[%0d] missing exp pc=%h", i, ep[i]); end
            else if (got[gb+i].pc !== ep[i] || got[gb+i].instr !== ei[i] || got[gb+i].comp !== ec[i]) begin
                bad++; $display("FAIL rvc[%0d] pc=%h instr=%h c=%b exp pc=%h instr=%h c=%b", i, got[gb+i].pc, got[gb+i].instr, got[gb+i].comp, ep[i], ei[i], ec[i]);
            end
        end
    endtask

    task automatic test_unaligned;
        logic [31:0] ep[2], ei[2];
        logic        ec[2];
        ep = '{32'h102, 32'h106};
        ei = '{32'h0000_0013, 32'h0000_0000};
        ec = '{1'b0, 1'b1};
        do_redirect(32'h102);
        wait_cyc(10);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (got.size() <= gb + i) begin bad++; $display("FAIL unaligned[%0d] missing exp pc=%h", i, ep[i]); end
            else if (got[gb+i].pc !== ep[i] || got[gb+i].instr !== ei[i] || got[gb+i].comp !== ec[i]) begin
                bad++; $display("FAIL unaligned[%0d] pc=%h instr=%h c=%b exp pc=%h instr=%h c=%b", i, got[gb+i].pc, got[gb+i].instr, got[gb+i].comp, ep[i], ei[i], ec[i]);
            end
        end
    endtask

    task automatic test_stale;
        int nb0;
        ready_i = 1'b0; lat = 3;
        wait_cyc(10);
        do_redirect(32'h400);
        wait_cyc(1);
        nb0 = nb;
        do_redirect(32'h300);
        total++; if (nb - nb0 != 2) begin bad++; $display("FAIL stale_issued got=%0d exp=2", nb - nb0); end
        total++; if (bq.size() != 2) begin bad++; $display("FAIL stale_inflight got=%0d exp=2", bq.size()); end
        ready_i = 1'b1;
        wait_cyc(15);
        total++;
        if (got.size() <= gb) begin bad++; $display("FAIL stale_first missing exp pc=300"); end
        else if (got[gb].pc !== 32'h300 || got[gb].instr !== 32'h000C_0013) begin
            bad++; $display("FAIL stale_first pc=%h instr=%h exp pc=300 instr=000c0013", got[gb].pc, got[gb].instr);
        end
        total++;
        if (got.size() <= gb + 1) begin bad++; $display("FAIL stale_second missing exp pc=304"); end
        else if (got[gb+1].pc !== 32'h304 || got[gb+1].instr !== 32'h000C_1013) begin
            bad++; $display("FAIL stale_second pc=%h instr=%h exp pc=304 instr=000c1013", got[gb+1].pc, got[gb+1].instr);
        end
    endtask

    task automatic test_backpressure;
        lat = 1; ready_i = 1'b0;
        do_redirect(32'h500);
        wait_cyc(9);
        total++;
        if (valid_o !== 1'b1 || pc_o !== 32'h500 || instr_o !== 32'h0014_0013) begin
            bad++; $display("FAIL bp_early v=%b pc=%h instr=%h exp v=1 pc=500 instr=00140013", valid_o, pc_o, instr_o);
        end
        wait_cyc(4);
        total++;
        if (valid_o !== 1'b1 || pc_o !== 32'h500 || instr_o !== 32'h0014_0013) begin
            bad++; $display("FAIL bp_stable v=%b pc=%h instr=%h exp v=1 pc=500 instr=00140013", valid_o, pc_o, instr_o);
        end
        total++; if (n_gnt - nb != 3) begin bad++; $display("FAIL bp_grants got=%0d exp=3", n_gnt - nb); end
        total++; if (req_o !== 1'b0)  begin bad++; $display("FAIL bp_req got=%b exp=0", req_o); end
    endtask

    task automatic test_fault;
        logic [31:0] ep[4];
        logic        ee[4];
        ep = '{32'h0, 32'h4, 32'h8, 32'hC};
        ee = '{1'b0, 1'b0, 1'b1, 1'b0};
        err_addr = 32'h8;
        do_redirect(32'h0);
        ready_i = 1'b1;
        wait_cyc(15);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got.size() <= gb + i) begin bad++; $display("FAIL fault[%0d] missing exp pc=%h", i, ep[i]); end
            else if (got[gb+i].pc !== ep[i] || got[gb+i].err !== ee[i]) begin
                bad++; $display("FAIL fault[%0d] pc=%h err=%b exp pc=%h err=%b", i, got[gb+i].pc, got[gb+i].err, ep[i], ee[i]);
            end
        end
        total++; if (got.size() != gb + 4) begin bad++; $display("FAIL fault_count got=%0d exp=4", got.size() - gb); end
        total++; if (n_gnt - nb != 4)      begin bad++; $display("FAIL fault_grants got=%0d exp=4", n_gnt - nb); end
        total++; if (req_o !== 1'b0)       begin bad++; $display("FAIL fault_req got=%b exp=0", req_o); end
        err_addr = 32'hFFFF_FFFF;
        do_redirect(32'h20);
        wait_cyc(10);
        total++;
        if (got.size() <= gb) begin bad++; $display("FAIL fault_resume missing exp pc=20"); end
        else if (got[gb].pc !== 32'h20 || got[gb].instr !== 32'h0000_8013 || got[gb].err !== 1'b0) begin
            bad++; $display("FAIL fault_resume pc=%h instr=%h err=%b exp pc=20 instr=00008013 err=0", got[gb].pc, got[gb].instr, got[gb].err);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = (32'(i) << 12) | 32'h13;
        mem['h80] = 32'h0001_0001;
        mem['h81] = 32'h0000_0013;
        mem['h40] = 32'h0013_0001;
        mem['h41] = 32'h0000_0000;
        redirect_i = 1'b0; redirect_pc_i = '0; ready_i = 1'b1;
        test_reset();
        test_stream();
        test_rvc();
        test_unaligned();
        test_stale();
        test_backpressure();
        test_fault();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
